regfile_arbiter: RTL

Single-port access controller for the architectural register file. Arbitrates two operand-read requesters (issue-stage rs1/rs2 fetch) and one commit-write requester onto the one shared regfile port. Write has priority, reads are round-robin, and a starvation counter bounds how long reads wait. Sits between issue/commit logic and `regfile`.

---
 rtl/regfile_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// Single-port regfile access controller: priority write, round-robin reads, bounded read starvation.
// Optional x0 write/read filtering is enabled with `define REGARB_X0_FILTER_EN.
module regfile_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rs1_valid,
   input  logic [ADDR_W-1:0] rs1_addr,
   output logic              rs1_ready,
   output logic              rs1_rvalid,
   output logic [DATA_W-1:0] rs1_rdata,
   input  logic              rs2_valid,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs2_ready,
   output logic              rs2_rvalid,
   output logic [DATA_W-1:0] rs2_rdata,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic              rf_en,
   output logic              rf_rw,
   output logic [ADDR_W-1:0] rf_id,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata
);

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   logic              ptr_q, ptr_d;
   logic [3:0]        starve_q, starve_d;
   logic              s1_vld_q, s1_tgt_q, s1_zero_q;
   logic              rv1_q, rv2_q;
   logic [DATA_W-1:0] d1_q, d2_q;

   logic go, wb_x0, starve_ok, wr_win, rd_pend, rd_win, pick2, rd_zero;
   logic [ADDR_W-1:0] rd_addr;

   always_comb begin
      go        = rdy & ~rst;
      wb_x0     = 1'b0;
      rd_zero   = 1'b0;
      starve_ok = (starve_q < LIM);
      rd_pend   = rs1_valid | rs2_valid;
      pick2     = rs2_valid & (~rs1_valid | ptr_q);
      rd_addr   = pick2 ? rs2_addr : rs1_addr;
`ifdef REGARB_X0_FILTER_EN
      wb_x0     = wb_valid & (wb_addr == '0);
      rd_zero   = (rd_addr == '0);
`endif
      // an x0 write is absorbed here, leaving the port free for a read
      wr_win    = go & wb_valid & starve_ok & ~wb_x0;
      rd_win    = go & rd_pend & ~wr_win;

      wb_ready  = go & wb_valid & (starve_ok | wb_x0);
      rs1_ready = rd_win & ~pick2;
      rs2_ready = rd_win & pick2;

      rf_en     = wr_win | rd_win;
      rf_rw     = wr_win;
      rf_id     = '0;
      rf_wdata  = '0;
      if (wr_win) begin
         rf_id    = wb_addr;
         rf_wdata = wb_data;
      end else if (rd_win) begin
         rf_id    = rd_addr;
      end

      ptr_d    = rd_win ? ~pick2 : ptr_q;
      starve_d = starve_q;
      if (rd_win || !rd_pend)
         starve_d = '0;
      else if (wr_win && starve_ok)
         starve_d = starve_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= 1'b0;
         starve_q  <= '0;
         s1_vld_q  <= 1'b0;
         s1_tgt_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         rv1_q     <= 1'b0;
         rv2_q     <= 1'b0;
         d1_q      <= '0;
         d2_q      <= '0;
      end else begin
         rv1_q <= 1'b0;
         rv2_q <= 1'b0;
         // everything below freezes while paused; rvalid stays a single-cycle pulse
         if (rdy) begin
            ptr_q     <= ptr_d;
            starve_q  <= starve_d;
            s1_vld_q  <= rd_win;
            s1_tgt_q  <= pick2;
            s1_zero_q <= rd_zero;
            if (s1_vld_q) begin
               if (s1_tgt_q) begin
                  d2_q  <= s1_zero_q ? '0 : rf_rdata;
                  rv2_q <= 1'b1;
               end else begin
                  d1_q  <= s1_zero_q ? '0 : rf_rdata;
                  rv1_q <= 1'b1;
               end
            end
         end
      end
   end

   assign rs1_rvalid = rv1_q;
   assign rs2_rvalid = rv2_q;
   assign rs1_rdata  = d1_q;
   assign rs2_rdata  = d2_q;

endmodule
